pipelined_ripple_add: RTL and testbench

//  Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshake on both sides.

---
 rtl/pipelined_ripple_add_if.sv | 27 ++
 rtl/pipelined_ripple_add.sv | 104 ++++++++++
 tb/tb_pipelined_ripple_add.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_ripple_add_if.sv
// Valid/ready bus for pipelined_ripple_add: operand beat in, result beat out.
// The DUT takes the slave view; the producer/consumer side takes master.
interface pipelined_ripple_add_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/pipelined_ripple_add.sv
// Pipelined ripple-carry adder/subtractor: STAGES slices of WIDTH/STAGES bits, one slice per
// stage, carry registered between stages, whole pipe advancing on a single global enable.
module pipelined_ripple_add #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    pipelined_ripple_add_if.slave io_bus
);
    localparam int unsigned SEG = WIDTH / STAGES;

    logic             w_en;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic             w_ovf_last;
    logic             r_ovf;

    assign w_b_eff   = io_bus.sub ? ~io_bus.b : io_bus.b;
    assign w_cin_eff = io_bus.sub | io_bus.c_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int unsigned DONE = (k + 1) * SEG;

        logic            r_valid;
        logic            r_carry;
        logic [DONE-1:0] r_sum;
        logic [SEG-1:0]  w_sa;
        logic [SEG-1:0]  w_sb;
        logic [SEG-1:0]  w_ss;
        logic            w_ci;
        logic            w_co;

        assign {w_co, w_ss} = {1'b0, w_sa} + {1'b0, w_sb} + {{SEG{1'b0}}, w_ci};

        if (k == 0) begin : g_head
            // Slice 0 ripples straight off the input port during the accepting cycle.
            assign w_sa = io_bus.a[SEG-1:0];
            assign w_sb = w_b_eff[SEG-1:0];
            assign w_ci = w_cin_eff;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_carry <= 1'b0;
                    r_sum   <= '0;
                end else if (w_en) begin
                    r_valid <= io_bus.in_valid;
                    r_carry <= w_co;
                    r_sum   <= w_ss;
                end
            end
        end else begin : g_body
            // Slice k waits k cycles in its own delay line before it is added.
            logic [SEG-1:0] r_da [k];
            logic [SEG-1:0] r_db [k];

            assign w_sa = r_da[k-1];
            assign w_sb = r_db[k-1];
            assign w_ci = g_st[k-1].r_carry;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_carry <= 1'b0;
                    r_sum   <= '0;
                    for (int m = 0; m < k; m++) begin
                        r_da[m] <= '0;
                        r_db[m] <= '0;
                    end
                end else if (w_en) begin
                    r_valid <= g_st[k-1].r_valid;
                    r_carry <= w_co;
                    r_sum   <= {w_ss, g_st[k-1].r_sum};
                    r_da[0] <= io_bus.a[k*SEG +: SEG];
                    r_db[0] <= w_b_eff[k*SEG +: SEG];
                    for (int m = 1; m < k; m++) begin
                        r_da[m] <= r_da[m-1];
                        r_db[m] <= r_db[m-1];
                    end
                end
            end
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit of the last slice.
    assign w_ovf_last = g_st[STAGES-1].w_co ^ (g_st[STAGES-1].w_sa[SEG-1] ^
                        g_st[STAGES-1].w_sb[SEG-1] ^ g_st[STAGES-1].w_ss[SEG-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_ovf <= w_ovf_last;
        end
    end

    assign w_en             = !g_st[STAGES-1].r_valid || io_bus.out_ready;
    assign io_bus.in_ready  = w_en;
    assign io_bus.out_valid = g_st[STAGES-1].r_valid;
    assign io_bus.sum       = g_st[STAGES-1].r_sum;
    assign io_bus.c_out     = g_st[STAGES-1].r_carry;
    assign io_bus.ovf       = r_ovf;
endmodule

// File: tb/tb_pipelined_ripple_add.sv
// Bench for pipelined_ripple_add: directed cases on a 32/4 instance, then a random stream
// shared by 32/4, 8/1, 8/8 and 64/4 instances, each scored against an arithmetic model.
module tb_pipelined_ripple_add;
    logic clk;
    logic rst_n;

    logic [3:0]  iv;
    logic [63:0] a64;
    logic [63:0] b64;
    logic        cin;
    logic        subm;
    logic        ordy;

    logic [3:0]  ov;
    logic [3:0]  ir;
    logic [3:0]  co;
    logic [3:0]  of;
    logic [63:0] sm [4];

    int checks   = 0;
    int failures = 0;

    // {ovf, c_out, sum} expected per instance, in acceptance order
    logic [65:0] q [4][$];

    pipelined_ripple_add_if #(.WIDTH(32)) if0 ();
    pipelined_ripple_add_if #(.WIDTH(8))  if1 ();
    pipelined_ripple_add_if #(.WIDTH(8))  if2 ();
    pipelined_ripple_add_if #(.WIDTH(64)) if3 ();

    pipelined_ripple_add #(.WIDTH(32), .STAGES(4)) u_dut0 (.clk(clk), .rst_n(rst_n), .io_bus(if0));
    pipelined_ripple_add #(.WIDTH(8),  .STAGES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .io_bus(if1));
    pipelined_ripple_add #(.WIDTH(8),  .STAGES(8)) u_dut2 (.clk(clk), .rst_n(rst_n), .io_bus(if2));
    pipelined_ripple_add #(.WIDTH(64), .STAGES(4)) u_dut3 (.clk(clk), .rst_n(rst_n), .io_bus(if3));

    assign if0.in_valid = iv[0];
    assign if1.in_valid = iv[1];
    assign if2.in_valid = iv[2];
    assign if3.in_valid = iv[3];
    assign if0.a = a64[31:0];
    assign if1.a = a64[7:0];
    assign if2.a = a64[7:0];
    assign if3.a = a64;
    assign if0.b = b64[31:0];
    assign if1.b = b64[7:0];
    assign if2.b = b64[7:0];
    assign if3.b = b64;
    assign {if0.c_in, if1.c_in, if2.c_in, if3.c_in} = {4{cin}};
    assign {if0.sub, if1.sub, if2.sub, if3.sub} = {4{subm}};
    assign {if0.out_ready, if1.out_ready, if2.out_ready, if3.out_ready} = {4{ordy}};

    assign ov = {if3.out_valid, if2.out_valid, if1.out_valid, if0.out_valid};
    assign ir = {if3.in_ready, if2.in_ready, if1.in_ready, if0.in_ready};
    assign co = {if3.c_out, if2.c_out, if1.c_out, if0.c_out};
    assign of = {if3.ovf, if2.ovf, if1.ovf, if0.ovf};
    assign sm[0] = {32'd0, if0.sum};
    assign sm[1] = {56'd0, if1.sum};
    assign sm[2] = {56'd0, if2.sum};
    assign sm[3] = if3.sum;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned width_of(input int d);
        case (d)
            0:       return 32;
            1:       return 8;
            2:       return 8;
            default: return 64;
        endcase
    endfunction

    // Plain modular arithmetic; overflow from the textbook sign rule.
    function automatic logic [65:0] model(input int unsigned w, input logic [63:0] a,
                                          input logic [63:0] b, input logic c, input logic s);
        logic [64:0] mask;
        logic [64:0] full;
        logic [63:0] am;
        logic [63:0] be;
        logic        ovf;
        mask = (65'd1 << w) - 65'd1;
        am   = a & mask[63:0];
        be   = (s ? ~b : b) & mask[63:0];
        full = {1'b0, am} + {1'b0, be} + {64'd0, (s ? 1'b1 : c)};
        ovf  = (am[w-1] == be[w-1]) && (full[w-1] != am[w-1]);
        return {ovf, full[w], full[63:0] & mask[63:0]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive after the falling edge, sample 1 time unit later, score drains/accepts.
    task automatic step(input logic [3:0] ivm, input logic [63:0] a, input logic [63:0] b,
                        input logic c, input logic s, input logic r);
        logic [65:0] e;
        @(negedge clk);
        iv = ivm; a64 = a; b64 = b; cin = c; subm = s; ordy = r;
        #1;
        for (int d = 0; d < 4; d++) begin
            if (ov[d] && ordy) begin
                e = (q[d].size() != 0) ? q[d][0] : '0;
                chk($sformatf("dut%0d beat", d), {1'b1, of[d], co[d], sm[d]},
                    {(q[d].size() != 0), e});
                if (q[d].size() != 0) void'(q[d].pop_front());
            end
            if (iv[d] && ir[d]) q[d].push_back(model(width_of(d), a, b, c, s));
        end
    endtask

    task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s, input logic [31:0] xs,
                          input logic xc, input logic xo);
        int lat;
        step(4'b0001, {32'd0, a}, {32'd0, b}, c, s, 1'b1);
        lat = 9;
        for (int n = 1; n <= 8; n++) begin
            step(4'b0000, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
            if (ov[0]) begin
                lat = n;
                break;
            end
        end
        chk({tag, " latency"}, lat, 4);
        chk({tag, " sum"}, sm[0], {32'd0, xs});
        chk({tag, " c_out"}, co[0], xc);
        chk({tag, " ovf"}, of[0], xo);
    endtask

    initial begin
        int got;
        int first;
        int last;
        int idx;
        int seen;
        logic        hold_pend;
        logic [67:0] hold_val;
        logic [63:0] ra;
        logic [63:0] rb;

        rst_n = 1'b1; iv = 4'b0; a64 = '0; b64 = '0; cin = 1'b0; subm = 1'b0; ordy = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        chk("reset out_valid", ov, 4'b0000);
        chk("reset in_ready", ir, 4'b1111);
        chk("reset result", {of[3], co[3], sm[3]}, 66'd0);
        @(negedge clk);
        rst_n = 1'b1;

        single("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        single("ovf add", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        single("c_in", 32'h0, 32'h0, 1'b1, 1'b0, 32'h1, 1'b0, 1'b0);
        single("sub neg", 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        single("sub ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Back-to-back stream
        got = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            step({3'b0, cyc < 8}, 64'(cyc + 1), 64'(10 * (cyc + 1)), 1'b0, 1'b0, 1'b1);
            if (cyc < 8) chk("stream in_ready", ir[0], 1'b1);
            if (ov[0]) begin
                got++;
                chk("stream sum", sm[0], 64'(11 * got));
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        chk("stream count", got, 8);
        chk("stream spacing", last - first, 7);

        // Backpressure for three cycles with a full pipe
        idx = 0; got = 0; hold_val = '0;
        for (int cyc = 0; cyc < 40 && !(idx == 10 && got == 10); cyc++) begin
            step({3'b0, idx < 10}, 64'(100 + idx), 64'(3 * idx), 1'b0, 1'b0,
                 !(cyc >= 5 && cyc <= 7));
            if (cyc >= 5 && cyc <= 7) chk("stall in_ready", ir[0], 1'b0);
            if (cyc == 5) hold_val = {ov[0], of[0], co[0], 1'b0, sm[0]};
            if (cyc >= 6 && cyc <= 8) chk("stall hold", {ov[0], of[0], co[0], 1'b0, sm[0]},
                                          hold_val);
            if (iv[0] && ir[0]) idx++;
            if (ov[0] && ordy) begin
                chk("stall order", sm[0], 64'(100 + 4 * got));
                got++;
            end
        end
        chk("stall delivered", got, 10);
        chk("stall drained", q[0].size(), 0);

        // Async reset with one beat presented and three in flight
        for (int i = 0; i < 4; i++) step(4'b0001, 64'(500 + i), 64'(i), 1'b0, 1'b0, 1'b1);
        step(4'b0000, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("pre-reset out_valid", ov[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset out_valid", ov[0], 1'b0);
        chk("async reset result", {of[0], co[0], sm[0]}, 66'd0);
        for (int d = 0; d < 4; d++) q[d].delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(4'b0000, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
            if (ov[0]) seen++;
        end
        chk("flushed beats", seen, 0);

        // Random stream into all four instances with random stalls and random sub
        hold_pend = 1'b0;
        for (int cyc = 0; cyc < 12000; cyc++) begin
            ra = {$urandom, $urandom};
            rb = ($urandom_range(7) == 0) ? ~ra : {$urandom, $urandom};
            step(($urandom_range(3) != 0) ? 4'b1111 : 4'b0000, ra, rb, 1'($urandom),
                 1'($urandom), $urandom_range(3) != 0);
            if (hold_pend) chk("rand hold", {ov[0], of[0], co[0], 1'b0, sm[0]}, hold_val);
            hold_pend = ov[0] && !ordy;
            hold_val  = {ov[0], of[0], co[0], 1'b0, sm[0]};
            for (int d = 0; d < 4; d++) chk($sformatf("dut%0d in_ready", d), ir[d],
                                            !ov[d] || ordy);
        end
        for (int i = 0; i < 16; i++) step(4'b0000, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
        for (int d = 0; d < 4; d++) chk($sformatf("dut%0d drained", d), q[d].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
